// File: rtl/mc_control_fsm.sv
// mc_control_fsm: multi-cycle control unit for the Dataflow datapath.
//
// Decodes OPCODE/FUNCT and sequences a MIPS-style multi-cycle datapath
// (lw, sw, R-type add/sub/and/or/slt, addi, beq, j). Adds an optional
// memory ready handshake with a wait timeout, an absorbing HALT state with
// a cause code, and a wrapping retired-instruction counter.
//
// Parameters:
//   MEM_HANDSHAKE  0: memory always single-cycle (MemRdy ignored)
//                  1: FETCH/MEMRD/MEMWR wait for MemRdy
//   WAIT_TIMEOUT   wait cycles allowed per memory access before HALT (0 = off)
//   CNT_W          width of InstrCount
//
// Ports:
//   CLK, RST            clock, synchronous active-high reset
//   OPCODE, FUNCT       instr[31:26], instr[5:0]
//   MemRdy              memory access completes this cycle
//   MtoRFSel, RFDSel    register-file write data / destination selects
//   IDSel               memory address select (PC / ALUOut)
//   ALUIn1Sel/ALUIn2Sel ALU operand selects
//   ALUSel              ALU operation
//   PCSel               next-PC select
//   IRWE/DMWE/PCWE/RFWE write enables, Branch = PC write on Zero
//   MemReq              memory access active
//   Halted, HaltCause   HALT indication (01 opcode, 10 funct, 11 timeout)
//   InstrCount          retired instructions, wraps
module mc_control_fsm #(
  parameter int unsigned MEM_HANDSHAKE = 0,
  parameter int unsigned WAIT_TIMEOUT  = 16,
  parameter int unsigned CNT_W         = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [5:0]       OPCODE,
  input  logic [5:0]       FUNCT,
  input  logic             MemRdy,
  output logic             MtoRFSel,
  output logic             RFDSel,
  output logic             IDSel,
  output logic             ALUIn1Sel,
  output logic [1:0]       ALUIn2Sel,
  output logic [2:0]       ALUSel,
  output logic [1:0]       PCSel,
  output logic             IRWE,
  output logic             DMWE,
  output logic             PCWE,
  output logic             RFWE,
  output logic             Branch,
  output logic             MemReq,
  output logic             Halted,
  output logic [1:0]       HaltCause,
  output logic [CNT_W-1:0] InstrCount
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  // The counter only has to hold WAIT_TIMEOUT-1: the cycle in which it
  // would reach WAIT_TIMEOUT is the one that triggers the halt.
  localparam int unsigned WCW = (WAIT_TIMEOUT > 1) ? $clog2(WAIT_TIMEOUT) : 1;
  localparam logic [WCW-1:0] WLIM = (WAIT_TIMEOUT > 0) ? WCW'(WAIT_TIMEOUT - 1) : '0;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMRD,
    S_MEMWB,
    S_MEMWR,
    S_EXEC_R,
    S_ALUWB,
    S_ADDI_EX,
    S_ADDI_WB,
    S_BRANCH,
    S_JUMP,
    S_HALT
  } state_t;

  state_t         state;
  logic [WCW-1:0] wcnt;
  logic           done;
  logic           timeout_hit;
  logic           funct_ok;
  logic [2:0]     r_alusel;

  assign done = (MEM_HANDSHAKE == 0) ? 1'b1 : MemRdy;

  // Only meaningful in memory states; elsewhere wcnt is held at zero.
  assign timeout_hit = (WAIT_TIMEOUT != 0) && !done && (wcnt == WLIM);

  always_comb begin
    funct_ok = 1'b1;
    r_alusel = 3'b010;
    case (FUNCT)
      FN_ADD:  r_alusel = 3'b010;
      FN_SUB:  r_alusel = 3'b110;
      FN_AND:  r_alusel = 3'b000;
      FN_OR:   r_alusel = 3'b001;
      FN_SLT:  r_alusel = 3'b111;
      default: funct_ok = 1'b0;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= S_FETCH;
      wcnt       <= '0;
      InstrCount <= '0;
      HaltCause  <= 2'b00;
    end else begin
      wcnt <= '0;
      case (state)
        S_FETCH, S_MEMRD, S_MEMWR: begin
          if (done) begin
            if (state == S_FETCH) begin
              state <= S_DECODE;
            end else if (state == S_MEMRD) begin
              state <= S_MEMWB;
            end else begin
              state      <= S_FETCH;
              InstrCount <= InstrCount + CNT_W'(1);
            end
          end else if (timeout_hit) begin
            state     <= S_HALT;
            HaltCause <= 2'b11;
          end else if (WAIT_TIMEOUT != 0) begin
            wcnt <= wcnt + WCW'(1);
          end
        end
        S_DECODE: begin
          case (OPCODE)
            OP_LW, OP_SW: state <= S_MEMADR;
            OP_RTYPE:     state <= S_EXEC_R;
            OP_BEQ:       state <= S_BRANCH;
            OP_ADDI:      state <= S_ADDI_EX;
            OP_J:         state <= S_JUMP;
            default: begin
              state     <= S_HALT;
              HaltCause <= 2'b01;
            end
          endcase
        end
        S_MEMADR: state <= (OPCODE == OP_SW) ? S_MEMWR : S_MEMRD;
        S_EXEC_R: begin
          if (funct_ok) begin
            state <= S_ALUWB;
          end else begin
            state     <= S_HALT;
            HaltCause <= 2'b10;
          end
        end
        S_ADDI_EX: state <= S_ADDI_WB;
        S_MEMWB, S_ALUWB, S_ADDI_WB, S_BRANCH, S_JUMP: begin
          state      <= S_FETCH;
          InstrCount <= InstrCount + CNT_W'(1);
        end
        S_HALT:  state <= S_HALT;
        default: state <= S_FETCH;
      endcase
    end
  end

  // Moore decode of the registered state; enables in memory states are
  // qualified by done, and RST suppresses every enable in its own cycle.
  always_comb begin
    MtoRFSel  = 1'b0;
    RFDSel    = 1'b0;
    IDSel     = 1'b0;
    ALUIn1Sel = 1'b0;
    ALUIn2Sel = 2'b00;
    ALUSel    = 3'b000;
    PCSel     = 2'b00;
    IRWE      = 1'b0;
    DMWE      = 1'b0;
    PCWE      = 1'b0;
    RFWE      = 1'b0;
    Branch    = 1'b0;
    MemReq    = 1'b0;
    Halted    = 1'b0;
    case (state)
      S_FETCH: begin
        MemReq    = 1'b1;
        ALUIn2Sel = 2'b01;
        ALUSel    = 3'b010;
        IRWE      = done;
        PCWE      = done;
      end
      S_DECODE: begin
        ALUIn2Sel = 2'b11;
        ALUSel    = 3'b010;
      end
      S_MEMADR, S_ADDI_EX: begin
        ALUIn1Sel = 1'b1;
        ALUIn2Sel = 2'b10;
        ALUSel    = 3'b010;
      end
      S_MEMRD: begin
        MemReq = 1'b1;
        IDSel  = 1'b1;
      end
      S_MEMWB: begin
        RFWE     = 1'b1;
        MtoRFSel = 1'b1;
      end
      S_MEMWR: begin
        MemReq = 1'b1;
        IDSel  = 1'b1;
        DMWE   = done;
      end
      S_EXEC_R: begin
        ALUIn1Sel = 1'b1;
        ALUSel    = r_alusel;
      end
      S_ALUWB: begin
        RFWE   = 1'b1;
        RFDSel = 1'b1;
      end
      S_ADDI_WB: RFWE = 1'b1;
      S_BRANCH: begin
        ALUIn1Sel = 1'b1;
        ALUSel    = 3'b110;
        PCSel     = 2'b01;
        Branch    = 1'b1;
      end
      S_JUMP: begin
        PCSel = 2'b10;
        PCWE  = 1'b1;
      end
      S_HALT:  Halted = 1'b1;
      default: ;
    endcase
    if (RST) begin
      IRWE   = 1'b0;
      DMWE   = 1'b0;
      PCWE   = 1'b0;
      RFWE   = 1'b0;
      Branch = 1'b0;
      MemReq = 1'b0;
    end
  end

endmodule

// File: tb/tb_mc_control_fsm.sv
// Testbench for mc_control_fsm: instance A (handshake, WAIT_TIMEOUT=4) and
// instance B (single-cycle memory, CNT_W=3) share clock, reset and opcode.
module tb_mc_control_fsm;

  typedef struct packed {
    logic       mto;
    logic       rfd;
    logic       id;
    logic       a1;
    logic [1:0] a2;
    logic [2:0] alu;
    logic [1:0] pcs;
    logic       irwe;
    logic       dmwe;
    logic       pcwe;
    logic       rfwe;
    logic       br;
    logic       memreq;
    logic       halted;
    logic [1:0] cause;
  } ctl_t;

  typedef struct {
    string       nm;
    bit          b;
    ctl_t        c;
    logic [31:0] cnt;
  } exp_t;

  typedef struct {
    string       nm;
    logic [5:0]  op;
    logic [5:0]  fn;
    int unsigned len;
    ctl_t [0:4]  seq;
  } instr_t;

  localparam logic [5:0] OP_R = 6'b000000, OP_J = 6'b000010, OP_BEQ = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000, OP_LW = 6'b100011, OP_SW = 6'b101011;

  // field groups: mto rfd id a1 _ a2 _ alu _ pcs _ irwe dmwe pcwe rfwe br memreq halted _ cause
  localparam ctl_t C_FETCH   = 20'b0000_01_010_00_1010010_00;
  localparam ctl_t C_FETCH_W = 20'b0000_01_010_00_0000010_00;
  localparam ctl_t C_FETCH_R = 20'b0000_01_010_00_0000000_00;
  localparam ctl_t C_DECODE  = 20'b0000_11_010_00_0000000_00;
  localparam ctl_t C_ALUIMM  = 20'b0001_10_010_00_0000000_00;
  localparam ctl_t C_MEMRD   = 20'b0010_00_000_00_0000010_00;
  localparam ctl_t C_MEMWB   = 20'b1000_00_000_00_0001000_00;
  localparam ctl_t C_MEMWR   = 20'b0010_00_000_00_0100010_00;
  localparam ctl_t C_MEMWR_W = 20'b0010_00_000_00_0000010_00;
  localparam ctl_t C_MEMWR_R = 20'b0010_00_000_00_0000000_00;
  localparam ctl_t C_ALUWB   = 20'b0100_00_000_00_0001000_00;
  localparam ctl_t C_ADDIWB  = 20'b0000_00_000_00_0001000_00;
  localparam ctl_t C_BRANCH  = 20'b0001_00_110_01_0000100_00;
  localparam ctl_t C_JUMP    = 20'b0000_00_000_10_0010000_00;

  logic             CLK, RST, mrdy_a, mrdy_b;
  logic [5:0]       OPCODE, FUNCT;
  logic             mto_a, rfd_a, id_a, a1_a, irwe_a, dmwe_a, pcwe_a, rfwe_a, br_a, mreq_a, hlt_a;
  logic [1:0]       a2_a, pcs_a, cause_a;
  logic [2:0]       alu_a;
  logic [31:0]      cnt_a;
  logic             mto_b, rfd_b, id_b, a1_b, irwe_b, dmwe_b, pcwe_b, rfwe_b, br_b, mreq_b, hlt_b;
  logic [1:0]       a2_b, pcs_b, cause_b;
  logic [2:0]       alu_b;
  logic [2:0]       cnt_b;
  ctl_t             oa, ob;

  int unsigned checks = 0;
  int unsigned errors = 0;
  exp_t        sb[$];
  instr_t      prog[$];

  assign oa = {mto_a, rfd_a, id_a, a1_a, a2_a, alu_a, pcs_a, irwe_a, dmwe_a, pcwe_a,
               rfwe_a, br_a, mreq_a, hlt_a, cause_a};
  assign ob = {mto_b, rfd_b, id_b, a1_b, a2_b, alu_b, pcs_b, irwe_b, dmwe_b, pcwe_b,
               rfwe_b, br_b, mreq_b, hlt_b, cause_b};

  mc_control_fsm #(.MEM_HANDSHAKE(1), .WAIT_TIMEOUT(4), .CNT_W(32)) dut_a (
    .CLK(CLK), .RST(RST), .OPCODE(OPCODE), .FUNCT(FUNCT), .MemRdy(mrdy_a),
    .MtoRFSel(mto_a), .RFDSel(rfd_a), .IDSel(id_a), .ALUIn1Sel(a1_a),
    .ALUIn2Sel(a2_a), .ALUSel(alu_a), .PCSel(pcs_a), .IRWE(irwe_a), .DMWE(dmwe_a),
    .PCWE(pcwe_a), .RFWE(rfwe_a), .Branch(br_a), .MemReq(mreq_a), .Halted(hlt_a),
    .HaltCause(cause_a), .InstrCount(cnt_a)
  );

  mc_control_fsm #(.MEM_HANDSHAKE(0), .WAIT_TIMEOUT(16), .CNT_W(3)) dut_b (
    .CLK(CLK), .RST(RST), .OPCODE(OPCODE), .FUNCT(FUNCT), .MemRdy(mrdy_b),
    .MtoRFSel(mto_b), .RFDSel(rfd_b), .IDSel(id_b), .ALUIn1Sel(a1_b),
    .ALUIn2Sel(a2_b), .ALUSel(alu_b), .PCSel(pcs_b), .IRWE(irwe_b), .DMWE(dmwe_b),
    .PCWE(pcwe_b), .RFWE(rfwe_b), .Branch(br_b), .MemReq(mreq_b), .Halted(hlt_b),
    .HaltCause(cause_b), .InstrCount(cnt_b)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic ctl_t c_exec(input logic [2:0] alu);
    ctl_t c;
    c = '0;
    c.a1 = 1'b1;
    c.alu = alu;
    return c;
  endfunction

  function automatic ctl_t c_halt(input logic [1:0] cause);
    ctl_t c;
    c = '0;
    c.halted = 1'b1;
    c.cause = cause;
    return c;
  endfunction

  function automatic instr_t mk(input string nm, input logic [5:0] op, input logic [5:0] fn,
                                input int unsigned len, input ctl_t s0, input ctl_t s1,
                                input ctl_t s2, input ctl_t s3, input ctl_t s4);
    instr_t t;
    t.nm = nm;
    t.op = op;
    t.fn = fn;
    t.len = len;
    t.seq[0] = s0;
    t.seq[1] = s1;
    t.seq[2] = s2;
    t.seq[3] = s3;
    t.seq[4] = s4;
    return t;
  endfunction

  // Sample on the falling edge, score every pending expectation, then
  // return just after the next rising edge for the following drive.
  task automatic cycle();
    exp_t        e;
    ctl_t        act;
    logic [31:0] acnt;
    @(negedge CLK);
    while (sb.size() != 0) begin
      e = sb.pop_front();
      if (e.b) begin
        act  = ob;
        acnt = {29'b0, cnt_b};
      end else begin
        act  = oa;
        acnt = cnt_a;
      end
      checks++;
      if (act !== e.c) begin
        errors++;
        $display("FAIL %s ctl: got %b expected %b", e.nm, act, e.c);
      end
      checks++;
      if (acnt !== e.cnt) begin
        errors++;
        $display("FAIL %s InstrCount: got %0d expected %0d", e.nm, acnt, e.cnt);
      end
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic step(input string nm, input logic [5:0] op, input logic [5:0] fn,
                      input logic rdy, input logic rst, input bit chk, input ctl_t ea,
                      input logic [31:0] cnta);
    OPCODE = op;
    FUNCT  = fn;
    mrdy_a = rdy;
    RST    = rst;
    if (chk) sb.push_back('{nm, 1'b0, ea, cnta});
    cycle();
  endtask

  task automatic sa(input string nm, input logic [5:0] op, input logic [5:0] fn,
                    input logic rdy, input ctl_t ea, input logic [31:0] cnta);
    step(nm, op, fn, rdy, 1'b0, 1'b1, ea, cnta);
  endtask

  task automatic do_reset();
    step("rst", 6'd0, 6'd0, 1'b1, 1'b1, 1'b0, '0, 32'd0);
  endtask

  initial begin
    logic [31:0] cnt_m;
    RST = 1'b1; OPCODE = '0; FUNCT = '0; mrdy_a = 1'b1; mrdy_b = 1'b0;

    prog.push_back(mk("lw",   OP_LW,   6'd0,       5, C_FETCH, C_DECODE, C_ALUIMM, C_MEMRD, C_MEMWB));
    prog.push_back(mk("sw",   OP_SW,   6'd0,       4, C_FETCH, C_DECODE, C_ALUIMM, C_MEMWR, C_FETCH));
    prog.push_back(mk("add",  OP_R,    6'b100000,  4, C_FETCH, C_DECODE, c_exec(3'b010), C_ALUWB, C_FETCH));
    prog.push_back(mk("addi", OP_ADDI, 6'd0,       4, C_FETCH, C_DECODE, C_ALUIMM, C_ADDIWB, C_FETCH));
    prog.push_back(mk("beq",  OP_BEQ,  6'd0,       3, C_FETCH, C_DECODE, C_BRANCH, C_FETCH, C_FETCH));
    prog.push_back(mk("j",    OP_J,    6'd0,       3, C_FETCH, C_DECODE, C_JUMP, C_FETCH, C_FETCH));
    prog.push_back(mk("or",   OP_R,    6'b100101,  4, C_FETCH, C_DECODE, c_exec(3'b001), C_ALUWB, C_FETCH));
    prog.push_back(mk("slt",  OP_R,    6'b101010,  4, C_FETCH, C_DECODE, c_exec(3'b111), C_ALUWB, C_FETCH));
    prog.push_back(mk("sub",  OP_R,    6'b100010,  4, C_FETCH, C_DECODE, c_exec(3'b110), C_ALUWB, C_FETCH));

    @(posedge CLK);
    #1;
    // Both instances now in FETCH with RST still high: enables forced low.
    sb.push_back('{"rst_hold_b", 1'b1, C_FETCH_R, 32'd0});
    step("rst_hold_a", 6'd0, 6'd0, 1'b1, 1'b1, 1'b1, C_FETCH_R, 32'd0);

    // Instance B program: per-cycle outputs and wrapping count (CNT_W=3).
    cnt_m = 0;
    RST = 1'b0;
    foreach (prog[i]) begin
      for (int unsigned k = 0; k < prog[i].len; k++) begin
        OPCODE = prog[i].op;
        FUNCT  = prog[i].fn;
        sb.push_back('{$sformatf("%s_c%0d", prog[i].nm, k), 1'b1, prog[i].seq[k], cnt_m});
        cycle();
      end
      cnt_m = (cnt_m + 1) % 8;
    end
    sb.push_back('{"prog_end_fetch", 1'b1, C_FETCH, cnt_m});
    cycle();

    // FETCH waits three cycles for MemRdy.
    do_reset();
    for (int unsigned i = 0; i < 3; i++) sa($sformatf("fetch_wait%0d", i), OP_J, 6'd0, 1'b0, C_FETCH_W, 0);
    sa("fetch_rdy", OP_J, 6'd0, 1'b1, C_FETCH, 0);
    sa("j_decode", OP_J, 6'd0, 1'b0, C_DECODE, 0);
    sa("j_jump", OP_J, 6'd0, 1'b0, C_JUMP, 0);
    sa("j_next_fetch", OP_J, 6'd0, 1'b1, C_FETCH, 1);

    // MEMRD timeout: four wait cycles then HALT cause 11.
    do_reset();
    sa("to_fetch", OP_LW, 6'd0, 1'b1, C_FETCH, 0);
    sa("to_decode", OP_LW, 6'd0, 1'b0, C_DECODE, 0);
    sa("to_memadr", OP_LW, 6'd0, 1'b0, C_ALUIMM, 0);
    for (int unsigned i = 0; i < 4; i++) sa($sformatf("to_memrd%0d", i), OP_LW, 6'd0, 1'b0, C_MEMRD, 0);
    sa("to_halt0", OP_LW, 6'd0, 1'b1, c_halt(2'b11), 0);
    sa("to_halt1", OP_LW, 6'd0, 1'b1, c_halt(2'b11), 0);

    // MemRdy exactly on the limit cycle completes the read.
    do_reset();
    sa("lim_fetch", OP_LW, 6'd0, 1'b1, C_FETCH, 0);
    sa("lim_decode", OP_LW, 6'd0, 1'b0, C_DECODE, 0);
    sa("lim_memadr", OP_LW, 6'd0, 1'b0, C_ALUIMM, 0);
    for (int unsigned i = 0; i < 3; i++) sa($sformatf("lim_memrd%0d", i), OP_LW, 6'd0, 1'b0, C_MEMRD, 0);
    sa("lim_memrd_rdy", OP_LW, 6'd0, 1'b1, C_MEMRD, 0);
    sa("lim_memwb", OP_LW, 6'd0, 1'b0, C_MEMWB, 0);
    sa("lim_fetch2", OP_LW, 6'd0, 1'b1, C_FETCH, 1);

    // Illegal opcode.
    do_reset();
    sa("ill_op_fetch", 6'b111111, 6'd0, 1'b1, C_FETCH, 0);
    sa("ill_op_decode", 6'b111111, 6'd0, 1'b1, C_DECODE, 0);
    sa("ill_op_halt", 6'b111111, 6'd0, 1'b1, c_halt(2'b01), 0);

    // Illegal funct; the EXEC_R cycle's ALUSel is unspecified so not scored.
    do_reset();
    sa("ill_fn_fetch", OP_R, 6'd0, 1'b1, C_FETCH, 0);
    sa("ill_fn_decode", OP_R, 6'd0, 1'b1, C_DECODE, 0);
    step("ill_fn_exec", OP_R, 6'd0, 1'b1, 1'b0, 1'b0, '0, 0);
    sa("ill_fn_halt", OP_R, 6'd0, 1'b1, c_halt(2'b10), 0);

    // Reset asserted during MEMWR with MemRdy high.
    do_reset();
    sa("rw_j_fetch", OP_J, 6'd0, 1'b1, C_FETCH, 0);
    sa("rw_j_decode", OP_J, 6'd0, 1'b1, C_DECODE, 0);
    sa("rw_j_jump", OP_J, 6'd0, 1'b1, C_JUMP, 0);
    sa("rw_fetch", OP_SW, 6'd0, 1'b1, C_FETCH, 1);
    sa("rw_decode", OP_SW, 6'd0, 1'b1, C_DECODE, 1);
    sa("rw_memadr", OP_SW, 6'd0, 1'b1, C_ALUIMM, 1);
    sa("rw_memwr_wait", OP_SW, 6'd0, 1'b0, C_MEMWR_W, 1);
    step("rw_memwr_rst", OP_SW, 6'd0, 1'b1, 1'b1, 1'b1, C_MEMWR_R, 1);
    sa("rw_after_rst", OP_SW, 6'd0, 1'b0, C_FETCH_W, 0);
    sa("rw_memwr_done", OP_SW, 6'd0, 1'b1, C_FETCH, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
